// File: rtl/i2c_master.sv
// Single-byte I2C master: START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP.
// SCL is a push-pull clock built from CLK_DIV system clocks per quarter-bit.
// SDA is open-drain: sda_oe=1 pulls the line low, 0 releases it to the pull-up.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       q_q, q_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;

  logic qtick;
  logic sample;
  logic slot_end;

  // Quarter tick and the two points of interest inside a bit slot.
  assign qtick    = busy_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign sample   = qtick && (q_q == 2'd2);
  assign slot_end = qtick && (q_q == 2'd3);

  // State register: every flop of the controller, cleared by the async reset.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together
  // from pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      q_q       <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  // Next-state: request accept, divider/phase advance, sampling and slot sequencing.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    q_d       = q_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    if (!busy_q) begin
      div_d = '0;
      q_d   = '0;
      bit_d = '0;
      if (start) begin
        busy_d    = 1'b1;
        state_d   = START;
        sh_d      = {slave_addr, rw};
        wdata_d   = wdata;
        rw_d      = rw;
        ack_err_d = 1'b0;
      end
    end else begin
      div_d = qtick ? '0 : div_q + 1'b1;
      if (qtick) q_d = q_q + 2'd1;

      // SDA is read on the tick that ends the first SCL-high quarter.
      if (sample) begin
        case (state_q)
          AACK, WACK: ack_err_d = ack_err_q | sda_in;
          RDATA:      sh_d      = {sh_q[6:0], sda_in};
          default:    ;
        endcase
      end

      if (slot_end) begin
        case (state_q)
          START: state_d = ADDR;
          ADDR: begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = AACK;
          end
          AACK: begin
            if (rw_q) begin
              state_d = RDATA;
            end else begin
              state_d = WDATA;
              sh_d    = wdata_q;
            end
          end
          WDATA: begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = WACK;
          end
          WACK:  state_d = STOP;
          RDATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RNACK;
          end
          RNACK: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (rw_q) rdata_d = sh_q;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output decode from next-state values so SCL/SDA leave clean flops in step.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      IDLE:        ;
      START:       sda_oe_d = q_d[1];
      ADDR, WDATA: begin
        scl_d    = q_d[1];
        sda_oe_d = ~sh_d[7];
      end
      STOP: begin
        scl_d    = (q_d != 2'd0);
        sda_oe_d = ~q_d[1];
      end
      default:     scl_d = q_d[1];
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a bus monitor plus a behavioural slave
// observe SCL/SDA; each task predicts the bit stream and results from rules.
module tb_i2c_master;

  localparam int CLK_DIV = 4;
  localparam int TXN_CLK = 80 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, ack_err, scl, sda_oe;
  logic [7:0] rdata;
  logic       slave_low = 1'b0;
  logic       sda;

  assign sda = ~(sda_oe | slave_low);

  int checks = 0;
  int errors = 0;

  // Slave configuration and monitor state.
  logic        slv_ack_a = 1'b1;
  logic        slv_ack_d = 1'b1;
  logic [7:0]  slv_rbyte = 8'h00;
  int          n_start = 0, n_stop = 0, n_viol = 0;
  int          nbits = 0, slot = 0;
  logic [18:0] rec = '0;
  logic        in_txn = 1'b0, rd_mode = 1'b0, addr_acked = 1'b0;
  logic        scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0]  rdata_exp = 8'h00;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .slave_addr(slave_addr),
    .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl(scl), .sda_oe(sda_oe), .sda_in(sda)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: runs on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    logic cur_scl, cur_sda;
    cur_scl = scl;
    cur_sda = sda;
    if (!rst_n) begin
      in_txn    = 1'b0;
      slave_low = 1'b0;
    end else begin
      if (scl_p && cur_scl && sda_p && !cur_sda) begin
        if (in_txn) n_viol++;
        else begin
          n_start++; in_txn = 1'b1; slot = -1; nbits = 0; rec = '0;
          addr_acked = 1'b0; rd_mode = 1'b0;
        end
      end else if (scl_p && cur_scl && !sda_p && cur_sda) begin
        if (in_txn) begin n_stop++; in_txn = 1'b0; end
        else n_viol++;
      end
      if (in_txn && !scl_p && cur_scl) begin
        rec = {rec[17:0], cur_sda};
        nbits++;
      end
      if (in_txn && scl_p && !cur_scl) begin
        slot++;
        slave_low = 1'b0;
        if (slot == 8) begin
          rd_mode    = rec[0];
          addr_acked = slv_ack_a;
          slave_low  = slv_ack_a;
        end else if (slot >= 9 && slot <= 16 && rd_mode && addr_acked) begin
          slave_low = !slv_rbyte[16-slot];
        end else if (slot == 17 && !rd_mode && addr_acked) begin
          slave_low = slv_ack_d;
        end
      end
    end
    scl_p = cur_scl;
    sda_p = cur_sda;
  end

  // One full transaction against the behavioural slave, with all result checks.
  task automatic run_txn(input string nm, input logic t_rw, input logic [6:0] t_addr,
                         input logic [7:0] t_wdata, input logic t_ack_a, input logic t_ack_d,
                         input logic [7:0] t_rbyte, input logic poke, input logic pulse_chk);
    logic [18:0] exp_bits;
    logic [7:0]  dbyte;
    logic        a2, exp_err, got;
    int          cyc, s0, p0, v0;
    dbyte    = t_rw ? (t_ack_a ? t_rbyte : 8'hFF) : t_wdata;
    a2       = t_rw ? 1'b1 : !(t_ack_a && t_ack_d);
    exp_bits = {t_addr, t_rw, !t_ack_a, dbyte, a2, 1'b0};
    exp_err  = !t_ack_a || (!t_rw && !t_ack_d);
    if (t_rw) rdata_exp = t_ack_a ? t_rbyte : 8'hFF;

    @(negedge clk);
    slv_ack_a = t_ack_a; slv_ack_d = t_ack_d; slv_rbyte = t_rbyte;
    s0 = n_start; p0 = n_stop; v0 = n_viol;
    start = 1'b1; rw = t_rw; slave_addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ack_err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b ack_err=%b done=%b, want 1 0 0", nm, busy, ack_err, done);
    end

    cyc = 0; got = 1'b0;
    while (!got && cyc < 4 * TXN_CLK) begin
      @(posedge clk);
      cyc++;
      #1;
      if (poke && cyc == 100) begin
        start = 1'b1; rw = ~t_rw; slave_addr = ~t_addr; wdata = ~t_wdata;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) got = 1'b1;
    end

    checks++;
    if (!got || cyc != TXN_CLK) begin
      errors++;
      $display("FAIL %s latency: done after %0d clk (seen=%b), want %0d", nm, cyc, got, TXN_CLK);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 0", nm, busy);
    end
    checks++;
    if (ack_err !== exp_err) begin
      errors++;
      $display("FAIL %s ack_err: got %b want %b", nm, ack_err, exp_err);
    end
    checks++;
    if (rdata !== rdata_exp) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", nm, rdata, rdata_exp);
    end
    checks++;
    if (nbits != 19 || rec !== exp_bits) begin
      errors++;
      $display("FAIL %s bits: got %0d bits %b want 19 bits %b", nm, nbits, rec, exp_bits);
    end
    checks++;
    if (n_start - s0 != 1 || n_stop - p0 != 1 || n_viol != v0) begin
      errors++;
      $display("FAIL %s protocol: starts=%0d stops=%0d violations=%0d, want 1 1 0",
               nm, n_start - s0, n_stop - p0, n_viol - v0);
    end
    if (pulse_chk) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done still %b one cycle later, want 0", nm, done);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        ack_err !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset: scl=%b sda_oe=%b busy=%b done=%b ack_err=%b rdata=%h, want 1 0 0 0 0 00",
               scl, sda_oe, busy, done, ack_err, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_bus: %0d cycles not scl=1 sda=1, want 0", bad);
    end
  endtask

  task automatic test_write();
    run_txn("write", 1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_read();
    run_txn("read", 1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
  endtask

  task automatic test_addr_nack();
    run_txn("addr_nack", 1'b0, 7'h50, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b0, 7'h2B, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    run_txn("b2b_second", 1'b1, 7'h11, 8'h00, 1'b1, 1'b1, 8'h96, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    @(negedge clk);
    slv_ack_a = 1'b1; slv_ack_d = 1'b1;
    start = 1'b1; rw = 1'b0; slave_addr = 7'h50; wdata = 8'hA5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (66) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || scl !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b scl=%b, want 1 0", busy, scl);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: scl=%b sda_oe=%b busy=%b, want 1 0 0", scl, sda_oe, busy);
    end
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done++;
    end
    rst_n = 1'b1;
    rdata_exp = 8'h00;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL rst_mid_done: done seen %0d cycles, want 0", seen_done);
    end
    run_txn("after_rst", 1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic       r_rw, r_aa, r_ad;
      logic [6:0] r_addr;
      logic [7:0] r_wd, r_rb;
      r_rw   = 1'($urandom_range(0, 1));
      r_addr = 7'($urandom);
      r_wd   = 8'($urandom);
      r_rb   = 8'($urandom);
      r_aa   = ($urandom_range(0, 3) != 0);
      r_ad   = ($urandom_range(0, 3) != 0);
      run_txn("random", r_rw, r_addr, r_wd, r_aa, r_ad, r_rb, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
